// File: rtl/ysyx_040750_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_040750_trap_ctrl
//
// Trap sequencer for the CSR unit. It handles three events:
//    - machine-timer interrupt entry
//    - ecall entry
//    - mret return
// For the asynchronous timer trap it holds fetch and waits for the pipeline
// to drain. It then issues the one-cycle CSR strobes, redirects IF to mtvec
// (traps) or mepc (mret), and flushes younger instructions.
//
// Ports
//    I_sys_clk         clock
//    I_rst_n           asynchronous reset, active low
//    I_timer_intr      pending-and-enabled machine timer interrupt (level)
//    I_wb_valid        an instruction is retiring in WB
//    I_wb_ecall        the retiring instruction is an ecall
//    I_wb_mret         the retiring instruction is an mret
//    I_wb_pc           PC of the retiring instruction
//    I_pipe_empty      no valid instruction left in ID/EX/MEM/WB
//    I_next_pc         architectural next PC, meaningful while the pipe is empty
//    I_csr_rd_data     combinational CSR read data (mtvec or mepc)
//    O_fetch_hold      freeze IF
//    O_flush           kill all instructions in IF..MEM
//    O_redirect_valid  one-cycle IF PC redirect
//    O_redirect_pc     redirect target
//    O_csr_valid       qualifies the CSR strobes below
//    O_csr_intr_wr     CSR trap-entry update
//    O_csr_intr_rd     CSR read of mtvec
//    O_csr_mret_wr     CSR mret update
//    O_csr_mret_rd     CSR read of mepc
//    O_intr_pc         value written to mepc
//    O_intr_no         value written to mcause
//    O_drain_timeout   sticky flag: a drain lasted DRAIN_MAX cycles
// ---------------------------------------------------------------------------
module ysyx_040750_trap_ctrl #(
   parameter int          PC_W        = 32,
   parameter int          DRAIN_MAX   = 15,
   parameter logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007,
   parameter logic [63:0] CAUSE_ECALL = 64'd11
) (
   input  logic            I_sys_clk,
   input  logic            I_rst_n,
   input  logic            I_timer_intr,
   input  logic            I_wb_valid,
   input  logic            I_wb_ecall,
   input  logic            I_wb_mret,
   input  logic [PC_W-1:0] I_wb_pc,
   input  logic            I_pipe_empty,
   input  logic [PC_W-1:0] I_next_pc,
   input  logic [63:0]     I_csr_rd_data,
   output logic            O_fetch_hold,
   output logic            O_flush,
   output logic            O_redirect_valid,
   output logic [PC_W-1:0] O_redirect_pc,
   output logic            O_csr_valid,
   output logic            O_csr_intr_wr,
   output logic            O_csr_intr_rd,
   output logic            O_csr_mret_wr,
   output logic            O_csr_mret_rd,
   output logic [PC_W-1:0] O_intr_pc,
   output logic [63:0]     O_intr_no,
   output logic            O_drain_timeout
);

   localparam int               CNT_W    = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      TRAP,
      MRET,
      REDIR
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  drain_cnt;
   logic              drain_timeout;
   logic [PC_W-1:0]   lat_pc;
   logic [63:0]       lat_cause;
   logic [PC_W-1:0]   lat_target;

   logic              sync_ecall;
   logic              sync_mret;
   logic              unused_csr_rd;

   // Synchronous events only count when the instruction really retires.
   assign sync_ecall = I_wb_valid & I_wb_ecall;
   assign sync_mret  = I_wb_valid & I_wb_mret;

   // Only the low PC_W bits of the CSR read data are used as a target.
   assign unused_csr_rd = ^I_csr_rd_data;

   // Sequencer state plus the values latched for the CSR write and the redirect.
   // Synchronous events always win over the timer, in IDLE and in DRAIN alike.
   // The timer is a level, so if it is dropped during DRAIN the trap is
   // abandoned. IDLE then simply sees it again once it is re-asserted.
   // The drain counter and its sticky timeout only observe a drain. They never
   // end one; the drain keeps waiting for the pipe or for the timer to go away.
   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state         <= IDLE;
         drain_cnt     <= '0;
         drain_timeout <= 1'b0;
         lat_pc        <= '0;
         lat_cause     <= '0;
         lat_target    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sync_ecall) begin
                  state     <= TRAP;
                  lat_pc    <= I_wb_pc;
                  lat_cause <= CAUSE_ECALL;
               end else if (sync_mret) begin
                  state <= MRET;
               end else if (I_timer_intr) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt != CNT_MAX) begin
                  drain_cnt <= drain_cnt + CNT_ONE;
               end
               if (drain_cnt == CNT_LAST) begin
                  drain_timeout <= 1'b1;
               end
               if (sync_ecall) begin
                  state     <= TRAP;
                  lat_pc    <= I_wb_pc;
                  lat_cause <= CAUSE_ECALL;
               end else if (sync_mret) begin
                  state <= MRET;
               end else if (!I_timer_intr) begin
                  state <= IDLE;
               end else if (I_pipe_empty) begin
                  state     <= TRAP;
                  lat_pc    <= I_next_pc;
                  lat_cause <= CAUSE_TIMER;
               end
            end
            TRAP: begin
               // mtvec is read in the same cycle as the trap-entry write,
               // so the target is the value before the update lands.
               lat_target <= I_csr_rd_data[PC_W-1:0];
               state      <= REDIR;
            end
            MRET: begin
               lat_target <= I_csr_rd_data[PC_W-1:0];
               state      <= REDIR;
            end
            REDIR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Moore outputs, decoded from the state register and the latched values.
   // The data outputs are forced to zero outside the cycle that uses them,
   // so the CSR file and IF never see stale values.
   assign O_fetch_hold     = (state != IDLE);
   assign O_flush          = (state == TRAP) || (state == MRET) || (state == REDIR);
   assign O_redirect_valid = (state == REDIR);
   assign O_redirect_pc    = (state == REDIR) ? lat_target : '0;
   assign O_csr_valid      = (state == TRAP) || (state == MRET);
   assign O_csr_intr_wr    = (state == TRAP);
   assign O_csr_intr_rd    = (state == TRAP);
   assign O_csr_mret_wr    = (state == MRET);
   assign O_csr_mret_rd    = (state == MRET);
   assign O_intr_pc        = (state == TRAP) ? lat_pc : '0;
   assign O_intr_no        = (state == TRAP) ? lat_cause : '0;
   assign O_drain_timeout  = drain_timeout;

endmodule

// File: tb/tb_ysyx_040750_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_040750_trap_ctrl
//
// Each scenario is described as a list of per-cycle input vectors together
// with the outputs the sequencer should show in that cycle. The expected
// outputs are built from the externally visible rules:
//    - what each kind of cycle drives
//    - how many cycles each event takes
//    - when the drain timeout appears
// The lists are then played against the DUT. Inputs change one time unit
// after the rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_040750_trap_ctrl;

   localparam int          PC_W        = 32;
   localparam int          DRAIN_MAX   = 15;
   localparam logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
   localparam logic [63:0] CAUSE_ECALL = 64'd11;

   logic            I_sys_clk;
   logic            I_rst_n;
   logic            I_timer_intr;
   logic            I_wb_valid;
   logic            I_wb_ecall;
   logic            I_wb_mret;
   logic [PC_W-1:0] I_wb_pc;
   logic            I_pipe_empty;
   logic [PC_W-1:0] I_next_pc;
   logic [63:0]     I_csr_rd_data;
   logic            O_fetch_hold;
   logic            O_flush;
   logic            O_redirect_valid;
   logic [PC_W-1:0] O_redirect_pc;
   logic            O_csr_valid;
   logic            O_csr_intr_wr;
   logic            O_csr_intr_rd;
   logic            O_csr_mret_wr;
   logic            O_csr_mret_rd;
   logic [PC_W-1:0] O_intr_pc;
   logic [63:0]     O_intr_no;
   logic            O_drain_timeout;

   typedef struct packed {
      logic            timer;
      logic            wb_valid;
      logic            ecall;
      logic            mret;
      logic [PC_W-1:0] wb_pc;
      logic            pipe_empty;
      logic [PC_W-1:0] next_pc;
      logic [63:0]     csr_rd;
   } stim_t;

   typedef struct packed {
      logic            hold;
      logic            flush;
      logic            rv;
      logic [PC_W-1:0] rpc;
      logic            cv;
      logic            iwr;
      logic            ird;
      logic            mwr;
      logic            mrd;
      logic [PC_W-1:0] ipc;
      logic [63:0]     ino;
      logic            tmo;
   } outs_t;

   stim_t stim_q[$];
   outs_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  tmo_sticky;

   ysyx_040750_trap_ctrl dut (
      .I_sys_clk        (I_sys_clk),
      .I_rst_n          (I_rst_n),
      .I_timer_intr     (I_timer_intr),
      .I_wb_valid       (I_wb_valid),
      .I_wb_ecall       (I_wb_ecall),
      .I_wb_mret        (I_wb_mret),
      .I_wb_pc          (I_wb_pc),
      .I_pipe_empty     (I_pipe_empty),
      .I_next_pc        (I_next_pc),
      .I_csr_rd_data    (I_csr_rd_data),
      .O_fetch_hold     (O_fetch_hold),
      .O_flush          (O_flush),
      .O_redirect_valid (O_redirect_valid),
      .O_redirect_pc    (O_redirect_pc),
      .O_csr_valid      (O_csr_valid),
      .O_csr_intr_wr    (O_csr_intr_wr),
      .O_csr_intr_rd    (O_csr_intr_rd),
      .O_csr_mret_wr    (O_csr_mret_wr),
      .O_csr_mret_rd    (O_csr_mret_rd),
      .O_intr_pc        (O_intr_pc),
      .O_intr_no        (O_intr_no),
      .O_drain_timeout  (O_drain_timeout)
   );

   // Free-running clock with a 10 time-unit period.
   initial I_sys_clk = 1'b0;
   always #5 I_sys_clk = ~I_sys_clk;

   // Abandons the run if it ever stops making progress.
   initial begin
      #2000000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected run to complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic applyStimulus(input stim_t s);
      I_timer_intr  = s.timer;
      I_wb_valid    = s.wb_valid;
      I_wb_ecall    = s.ecall;
      I_wb_mret     = s.mret;
      I_wb_pc       = s.wb_pc;
      I_pipe_empty  = s.pipe_empty;
      I_next_pc     = s.next_pc;
      I_csr_rd_data = s.csr_rd;
   endtask

   function automatic outs_t observe();
      outs_t o;
      o.hold  = O_fetch_hold;
      o.flush = O_flush;
      o.rv    = O_redirect_valid;
      o.rpc   = O_redirect_pc;
      o.cv    = O_csr_valid;
      o.iwr   = O_csr_intr_wr;
      o.ird   = O_csr_intr_rd;
      o.mwr   = O_csr_mret_wr;
      o.mrd   = O_csr_mret_rd;
      o.ipc   = O_intr_pc;
      o.ino   = O_intr_no;
      o.tmo   = O_drain_timeout;
      return o;
   endfunction

   // Expected outputs for each kind of cycle.
   function automatic outs_t ph_idle();
      outs_t o = '0;
      o.tmo = tmo_sticky;
      return o;
   endfunction

   function automatic outs_t ph_drain(input int j);
      outs_t o = '0;
      o.hold = 1'b1;
      o.tmo  = tmo_sticky || (j >= DRAIN_MAX);
      return o;
   endfunction

   function automatic outs_t ph_trap(input logic [PC_W-1:0] pc, input logic [63:0] cause);
      outs_t o = '0;
      o.hold  = 1'b1;
      o.flush = 1'b1;
      o.cv    = 1'b1;
      o.iwr   = 1'b1;
      o.ird   = 1'b1;
      o.ipc   = pc;
      o.ino   = cause;
      o.tmo   = tmo_sticky;
      return o;
   endfunction

   function automatic outs_t ph_mret();
      outs_t o = '0;
      o.hold  = 1'b1;
      o.flush = 1'b1;
      o.cv    = 1'b1;
      o.mwr   = 1'b1;
      o.mrd   = 1'b1;
      o.tmo   = tmo_sticky;
      return o;
   endfunction

   function automatic outs_t ph_redir(input logic [PC_W-1:0] target);
      outs_t o = '0;
      o.hold  = 1'b1;
      o.flush = 1'b1;
      o.rv    = 1'b1;
      o.rpc   = target;
      o.tmo   = tmo_sticky;
      return o;
   endfunction

   // Random inputs with the timer low and no ecall/mret actually retiring.
   function automatic stim_t quiet();
      stim_t s;
      s.timer      = 1'b0;
      s.wb_valid   = 1'($urandom_range(0, 1));
      s.ecall      = s.wb_valid ? 1'b0 : 1'($urandom_range(0, 1));
      s.mret       = (s.wb_valid || s.ecall) ? 1'b0 : 1'($urandom_range(0, 1));
      s.wb_pc      = $urandom;
      s.pipe_empty = 1'($urandom_range(0, 1));
      s.next_pc    = $urandom;
      s.csr_rd     = {$urandom, $urandom};
      return s;
   endfunction

   // Random inputs with the timer low and arbitrary WB events, which must be ignored.
   function automatic stim_t noisy();
      stim_t s = quiet();
      s.wb_valid = 1'($urandom_range(0, 1));
      s.ecall    = 1'($urandom_range(0, 1));
      s.mret     = 1'($urandom_range(0, 1));
      return s;
   endfunction

   task automatic push(input stim_t s, input outs_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) push(quiet(), ph_idle());
   endtask

   // Timer trap: the pipe is busy for 'busy' drain cycles, then empties.
   task automatic add_timer(input int busy, input logic [PC_W-1:0] np, input logic [PC_W-1:0] mtvec);
      stim_t s;
      s = quiet();
      s.timer = 1'b1;
      push(s, ph_idle());
      for (int j = 0; j <= busy; j++) begin
         s = quiet();
         s.timer      = 1'b1;
         s.pipe_empty = (j == busy);
         if (j == busy) s.next_pc = np;
         push(s, ph_drain(j));
      end
      if (busy + 1 >= DRAIN_MAX) tmo_sticky = 1'b1;
      s = noisy();
      s.csr_rd[PC_W-1:0] = mtvec;
      push(s, ph_trap(np, CAUSE_TIMER));
      push(noisy(), ph_redir(mtvec));
   endtask

   // Ecall trap. When drain_k < 0 it retires straight from idle, with the
   // timer at level timer0. Otherwise a timer drain is running and the
   // ecall retires in drain cycle drain_k.
   task automatic add_ecall(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] mtvec,
                            input logic timer0, input int drain_k);
      stim_t s;
      if (drain_k < 0) begin
         s = quiet();
         s.timer    = timer0;
         s.wb_valid = 1'b1;
         s.ecall    = 1'b1;
         s.mret     = 1'($urandom_range(0, 1));
         s.wb_pc    = pc;
         push(s, ph_idle());
      end else begin
         s = quiet();
         s.timer = 1'b1;
         push(s, ph_idle());
         for (int j = 0; j <= drain_k; j++) begin
            s = quiet();
            s.timer      = 1'b1;
            s.pipe_empty = 1'b0;
            if (j == drain_k) begin
               s.wb_valid   = 1'b1;
               s.ecall      = 1'b1;
               s.mret       = 1'($urandom_range(0, 1));
               s.wb_pc      = pc;
               s.pipe_empty = 1'($urandom_range(0, 1));
            end
            push(s, ph_drain(j));
         end
         if (drain_k + 1 >= DRAIN_MAX) tmo_sticky = 1'b1;
      end
      s = noisy();
      s.csr_rd[PC_W-1:0] = mtvec;
      push(s, ph_trap(pc, CAUSE_ECALL));
      push(noisy(), ph_redir(mtvec));
   endtask

   task automatic add_mret(input logic [PC_W-1:0] mepc, input logic timer0);
      stim_t s;
      s = quiet();
      s.timer    = timer0;
      s.wb_valid = 1'b1;
      s.ecall    = 1'b0;
      s.mret     = 1'b1;
      push(s, ph_idle());
      s = noisy();
      s.csr_rd[PC_W-1:0] = mepc;
      push(s, ph_mret());
      push(noisy(), ph_redir(mepc));
   endtask

   // Timer raised, then dropped in drain cycle k while the pipe is still busy.
   task automatic add_abort(input int k);
      stim_t s;
      s = quiet();
      s.timer = 1'b1;
      push(s, ph_idle());
      for (int j = 0; j <= k; j++) begin
         s = quiet();
         s.timer      = (j < k);
         s.pipe_empty = 1'b0;
         push(s, ph_drain(j));
      end
      if (k + 1 >= DRAIN_MAX) tmo_sticky = 1'b1;
   endtask

   task automatic test_reset();
      outs_t o;
      stim_t s;
      I_rst_n = 1'b0;
      tmo_sticky = 1'b0;
      applyStimulus(quiet());
      @(posedge I_sys_clk); #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", o, outs_t'('0));
      end
      s = quiet();
      s.timer    = 1'b1;
      s.wb_valid = 1'b1;
      s.ecall    = 1'b1;
      applyStimulus(s);
      @(posedge I_sys_clk); #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ignores_events: got %h expected %h", o, outs_t'('0));
      end
      I_rst_n = 1'b1;
      add_idle(3);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_timer();
      outs_t o;
      add_timer(0, 32'h8000_0040, 32'h8000_1000);
      add_idle(1);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL timer_trap cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_ecall();
      outs_t o;
      add_ecall(32'h8000_0100, 32'h8000_1000, 1'b0, -1);
      add_ecall($urandom, $urandom, 1'b1, -1);
      add_idle(1);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL ecall_trap cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_mret();
      outs_t o;
      add_mret(32'h8000_0104, 1'b0);
      add_mret($urandom, 1'b1);
      add_idle(1);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL mret_return cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_priority();
      outs_t o;
      logic [PC_W-1:0] mtvec;
      mtvec = $urandom;
      add_ecall($urandom, mtvec, 1'b1, -1);
      add_idle(3);
      add_mret($urandom, 1'b0);
      add_timer($urandom_range(0, 3), $urandom, mtvec);
      add_idle(1);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL sync_beats_timer cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_abort();
      outs_t o;
      add_abort(0);
      add_abort($urandom_range(1, 6));
      add_idle(2);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL timer_abort cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_random();
      outs_t o;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0:       add_timer($urandom_range(0, 8), $urandom, $urandom);
            1:       add_ecall($urandom, $urandom, 1'($urandom_range(0, 1)), -1);
            2:       add_ecall($urandom, $urandom, 1'b1, $urandom_range(0, 6));
            3:       add_mret($urandom, 1'($urandom_range(0, 1)));
            default: add_abort($urandom_range(0, 6));
         endcase
         add_idle($urandom_range(0, 2));
      end
      add_idle(1);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL random_mix cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_drain_timeout();
      outs_t o;
      add_timer(20, $urandom, $urandom);
      add_idle(3);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL drain_timeout cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   task automatic test_reset_mid_trap();
      outs_t o;
      stim_t s;
      s = quiet();
      s.wb_valid = 1'b1;
      s.ecall    = 1'b1;
      s.mret     = 1'b0;
      s.wb_pc    = 32'h8000_0200;
      applyStimulus(s);
      @(negedge I_sys_clk);
      o = observe();
      checks++;
      if (o !== ph_idle()) begin
         errors++;
         $display("[TB] FAIL reset_mid_pre: got %h expected %h", o, ph_idle());
      end
      @(posedge I_sys_clk); #1;
      s = noisy();
      s.csr_rd[PC_W-1:0] = 32'h8000_1000;
      applyStimulus(s);
      @(negedge I_sys_clk);
      o = observe();
      checks++;
      if (o !== ph_trap(32'h8000_0200, CAUSE_ECALL)) begin
         errors++;
         $display("[TB] FAIL reset_mid_trap: got %h expected %h", o, ph_trap(32'h8000_0200, CAUSE_ECALL));
      end
      #2;
      I_rst_n = 1'b0;
      tmo_sticky = 1'b0;
      #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_async: got %h expected %h", o, outs_t'('0));
      end
      @(posedge I_sys_clk); #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_hold: got %h expected %h", o, outs_t'('0));
      end
      I_rst_n = 1'b1;
      add_idle(4);
      for (int cyc = 0; stim_q.size() > 0; cyc++) begin
         outs_t e = exp_q.pop_front();
         applyStimulus(stim_q.pop_front());
         @(negedge I_sys_clk);
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid_after cycle %0d: got %h expected %h", cyc, o, e);
         end
         @(posedge I_sys_clk); #1;
      end
   endtask

   // Runs every scenario in order, then prints the summary line.
   initial begin
      test_reset();
      test_timer();
      test_ecall();
      test_mret();
      test_priority();
      test_abort();
      test_random();
      test_drain_timeout();
      test_reset_mid_trap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
